// File: rtl/plic_core.sv
// plic_core: platform-level interrupt controller core for a single target.
// Per-source gateways (level or rising-edge) feed pending bits. Enabled
// pending sources are arbitrated by priority (ties go to the lowest ID), and
// the winner is compared against the target threshold to raise irq. Claim
// moves the winner from pending to in-service. Complete releases it.
module plic_core #(
  parameter int N_SRC  = 8,
  parameter int PRIO_W = 3,
  localparam int ID_W  = $clog2(N_SRC + 1)
) (
  input  logic              CLK100MHZ,
  input  logic              CPU_RESETN,
  input  logic [N_SRC-1:0]  src,
  input  logic [N_SRC-1:0]  edge_mode,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_sel,
  input  logic [ID_W-1:0]   cfg_idx,
  input  logic [PRIO_W-1:0] cfg_data,
  input  logic              claim,
  output logic [ID_W-1:0]   claim_id,
  output logic              claim_valid,
  input  logic              complete,
  input  logic [ID_W-1:0]   complete_id,
  output logic              irq
);

  // Array index i holds the state of source ID i+1.
  logic [PRIO_W-1:0] prio_q [N_SRC];
  logic [PRIO_W-1:0] prio_d [N_SRC];
  logic [N_SRC-1:0]  enable_q, enable_d;
  logic [PRIO_W-1:0] threshold_q, threshold_d;
  logic [N_SRC-1:0]  pending_q, pending_d;
  logic [N_SRC-1:0]  in_service_q, in_service_d;
  logic [N_SRC-1:0]  src_prev_q, src_prev_d;
  logic [ID_W-1:0]   best_id_q, best_id_d;
  logic [PRIO_W-1:0] best_prio_q, best_prio_d;
  logic              irq_q, irq_d;
  logic              claim_valid_q, claim_valid_d;
  logic [ID_W-1:0]   claim_id_q, claim_id_d;

  logic [N_SRC-1:0]  gw_set;
  logic              claim_fire;

  // A gateway may raise a new request only when the source is idle (neither
  // pending nor in service). An edge-mode source additionally needs a 0->1
  // transition; edges arriving while busy are dropped.
  assign gw_set = src & ~pending_q & ~in_service_q & ~(edge_mode & src_prev_q);

  // A claim is only granted when irq was asserted; irq implies best_id != 0.
  assign claim_fire = claim & irq_q;

  // Configuration writes: out-of-range IDs fall through every compare.
  always_comb begin
    prio_d      = prio_q;
    enable_d    = enable_q;
    threshold_d = threshold_q;
    if (cfg_we) begin
      case (cfg_sel)
        2'd0: begin
          for (int i = 0; i < N_SRC; i++) begin
            if (cfg_idx == ID_W'(i + 1)) prio_d[i] = cfg_data;
          end
        end
        2'd1: begin
          for (int i = 0; i < N_SRC; i++) begin
            if (cfg_idx == ID_W'(i + 1)) enable_d[i] = cfg_data[0];
          end
        end
        2'd2:    threshold_d = cfg_data;
        default: ;
      endcase
    end
  end

  // Gateway, claim and completion update of pending / in-service. The claim
  // set is applied last so a same-cycle complete of the claimed ID loses.
  always_comb begin
    pending_d    = pending_q | gw_set;
    in_service_d = in_service_q;
    src_prev_d   = src;
    for (int i = 0; i < N_SRC; i++) begin
      if (complete && complete_id == ID_W'(i + 1)) in_service_d[i] = 1'b0;
      if (claim_fire && best_id_q == ID_W'(i + 1)) begin
        pending_d[i]    = 1'b0;
        in_service_d[i] = 1'b1;
      end
    end
  end

  // Arbitration works on next-state pending and configuration so the
  // registered winner never repeats an ID that was just claimed.
  always_comb begin
    best_id_d   = '0;
    best_prio_d = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (pending_d[i] && enable_d[i] && (prio_d[i] > best_prio_d)) begin
        best_prio_d = prio_d[i];
        best_id_d   = ID_W'(i + 1);
      end
    end
    irq_d = (best_prio_d > threshold_d);
  end

  // Claim response: pulse valid for every claim, and hold the ID until the
  // next claim arrives.
  always_comb begin
    claim_valid_d = claim;
    claim_id_d    = claim_id_q;
    if (claim) claim_id_d = claim_fire ? best_id_q : '0;
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      for (int i = 0; i < N_SRC; i++) prio_q[i] <= '0;
      enable_q      <= '0;
      threshold_q   <= '0;
      pending_q     <= '0;
      in_service_q  <= '0;
      src_prev_q    <= '0;
      best_id_q     <= '0;
      best_prio_q   <= '0;
      irq_q         <= 1'b0;
      claim_valid_q <= 1'b0;
      claim_id_q    <= '0;
    end else begin
      for (int i = 0; i < N_SRC; i++) prio_q[i] <= prio_d[i];
      enable_q      <= enable_d;
      threshold_q   <= threshold_d;
      pending_q     <= pending_d;
      in_service_q  <= in_service_d;
      src_prev_q    <= src_prev_d;
      best_id_q     <= best_id_d;
      best_prio_q   <= best_prio_d;
      irq_q         <= irq_d;
      claim_valid_q <= claim_valid_d;
      claim_id_q    <= claim_id_d;
    end
  end

  assign irq         = irq_q;
  assign claim_valid = claim_valid_q;
  assign claim_id    = claim_id_q;

endmodule

// File: doc/plic_core.md
PLIC_CORE -- requirements
Module: plic_core

Interface
REQ-001 The block SHALL expose parameter N_SRC, default 8, number of interrupt sources, legal range 2..31.
REQ-002 The block SHALL expose parameter PRIO_W, default 3, priority and threshold width in bits.
REQ-003 The block SHALL derive ID_W = clog2(N_SRC+1); source IDs are 1..N_SRC and ID 0 means "none".
REQ-004 CLK100MHZ  in  1  sole clock; all state updates on its rising edge.
REQ-005 CPU_RESETN  in  1  reset, asynchronous assert, active-low.
REQ-006 src  in  N_SRC  interrupt request lines, bit i-1 = source i, synchronous to CLK100MHZ.
REQ-007 edge_mode  in  N_SRC  per-source gateway mode: 1 = rising-edge, 0 = level.
REQ-008 cfg_we  in  1  configuration write strobe.
REQ-009 cfg_sel  in  2  write target: 0 = priority, 1 = enable, 2 = threshold, 3 = reserved.
REQ-010 cfg_idx  in  ID_W  target source ID for priority/enable writes.
REQ-011 cfg_data  in  PRIO_W  write data; enable writes use bit 0 only.
REQ-012 claim  in  1  single-cycle claim request.
REQ-013 claim_id  out  ID_W  claimed ID, 0 if nothing eligible.
REQ-014 claim_valid  out  1  one-cycle pulse qualifying claim_id.
REQ-015 complete  in  1  single-cycle completion strobe.
REQ-016 complete_id  in  ID_W  ID being completed.
REQ-017 irq  out  1  registered interrupt notification to the target.

Function
REQ-018 Level gateway SHALL set pending[i] when src high, pending[i]=0 and in_service[i]=0.
REQ-019 Edge gateway SHALL set pending[i] on src rising edge (src=1, previous-cycle src=0) when pending[i]=0 and in_service[i]=0; edges otherwise SHALL be dropped.
REQ-020 Eligible = pending & enable & priority>0; arbiter SHALL select highest priority, ties to lowest ID, registering best_id/best_prio one cycle after the inputs change.
REQ-021 irq SHALL be 1 exactly when best_prio > threshold (strict), registered with best_id.
REQ-022 On claim with irq=1, next cycle claim_valid=1, claim_id=best_id, pending[best_id] cleared, in_service[best_id] set.
REQ-023 On claim with irq=0, next cycle claim_valid=1, claim_id=0, no state change.
REQ-024 Arbiter SHALL compute from post-claim pending/in_service so back-to-back claims never return the same nonzero ID.
REQ-025 complete SHALL clear in_service[complete_id]; ID 0, ID>N_SRC or not-in-service SHALL be ignored.
REQ-026 Claim and complete of the same ID in one cycle: claim wins, in_service stays 1.
REQ-027 cfg writes with cfg_idx 0 or >N_SRC SHALL be ignored for sel 0/1; sel 2 ignores cfg_idx; sel 3 no effect.
REQ-028 Disabling a pending source SHALL retain pending; it re-enters arbitration when re-enabled.
REQ-029 Priority/threshold changes SHALL affect irq within 2 cycles of the write.
REQ-030 claim_id SHALL hold its value until the next claim.

Reset
REQ-031 CPU_RESETN low SHALL immediately clear pending, in_service, priorities, enables, threshold, src history, best_id, best_prio, irq, claim_valid, claim_id.
REQ-032 Reset mid-service SHALL drop all in-service state; level sources still high re-pend 1 cycle after release only once re-enabled with priority>0.

Verification
REQ-033 Src 3 level prio 2, enabled, threshold 0, src[2] high -> irq=1 within 2 cycles; claim -> claim_id=3; irq=0 until complete(3), then irq re-asserts while src high.
REQ-034 Src 2 and 5 both prio 4 pending -> claim returns 2, second back-to-back claim returns 5, third returns 0.
REQ-035 Src 1 edge mode, three pulses while in service -> only one claim returns 1; pulse after complete(1) -> new claim returns 1.
REQ-036 Threshold 3, single source prio 3 pending -> irq=0; priority written 4 -> irq=1 within 2 cycles.
REQ-037 CPU_RESETN pulsed low with two sources in service -> all outputs 0 during reset; after release no irq until reconfigured.
REQ-038 Claim and complete(ID 4) same cycle with 4 best -> claim_id=4, in_service[4]=1.
